// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI mode-0 master controller.
// Imported by the controller top and its half-period counter.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_HOLD = 3'd4,
        ST_GAP  = 3'd5
    } spi_ctrl_state_e;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Loadable down-counter; expire ticks on the last cycle
// of each HALF_DIV-cycle window after a load.
module spi_half_period_cnt
    import spi_ctrl_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int CW = cnt_w(HALF_DIV);
    localparam logic [CW-1:0] LOAD_V = CW'(HALF_DIV);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_V;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign expire = (cnt_q == ONE);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: command/response stream to cs_n/sck/mosi/miso,
// with multi-word bursts held under one chip-select assertion.
module spi_master_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 2,
    parameter int CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_last,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              cs_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    localparam int BW = cnt_w(DATA_W);
    localparam int GW = cnt_w(CS_GAP);
    localparam logic [BW-1:0] BITS  = BW'(DATA_W);
    localparam logic [BW-1:0] B_ONE = BW'(1);
    localparam logic [GW-1:0] GAP_V = GW'(CS_GAP);
    localparam logic [GW-1:0] G_ONE = GW'(1);

    spi_ctrl_state_e state_q;
    spi_ctrl_state_e state_d;

    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bit_q;
    logic [GW-1:0]     gap_q;
    logic              last_q;

    logic accept;
    logic expire;
    logic hp_load;
    logic go_high;
    logic go_low;
    logic done;
    logic all_bits;
    logic sample;

    assign accept   = cmd_valid & cmd_ready;
    assign all_bits = (bit_q == BITS);
    assign sample   = go_high & (CPHA == 1'b0);

    spi_half_period_cnt #(
        .HALF_DIV (HALF_DIV)
    ) u_hp_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (hp_load),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hp_load = 1'b0;
        go_high = 1'b0;
        go_low  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_d = ST_LEAD;
                    hp_load = 1'b1;
                end
            end
            ST_LEAD: begin
                if (expire) begin
                    state_d = ST_HIGH;
                    hp_load = 1'b1;
                    go_high = 1'b1;
                end
            end
            ST_HIGH: begin
                if (expire) begin
                    state_d = ST_LOW;
                    hp_load = !all_bits;
                    go_low  = 1'b1;
                end
            end
            ST_LOW: begin
                // final falling edge ends the word without a full half period
                if (all_bits) begin
                    done    = 1'b1;
                    state_d = last_q ? ST_GAP : ST_HOLD;
                end else if (expire) begin
                    state_d = ST_HIGH;
                    hp_load = 1'b1;
                    go_high = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q <= G_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            last_q    <= 1'b0;
            cs_n      <= 1'b1;
            sck       <= CPOL;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            cmd_ready <= (state_d == ST_IDLE) || (state_d == ST_HOLD);
            busy      <= (state_d != ST_IDLE);
            if (accept) begin
                cs_n    <= 1'b0;
                sck     <= CPOL;
                mosi    <= cmd_data[DATA_W-1];
                shift_q <= cmd_data;
                last_q  <= cmd_last;
                bit_q   <= '0;
            end
            if (go_high) begin
                sck   <= ~CPOL;
                bit_q <= bit_q + B_ONE;
            end
            // receive bits enter the LSB as transmit bits leave the MSB
            if (sample) begin
                shift_q <= {shift_q[DATA_W-2:0], miso};
            end
            if (go_low) begin
                sck <= CPOL;
                if (!all_bits) begin
                    mosi <= shift_q[DATA_W-1];
                end
            end
            if (done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= shift_q;
                if (last_q) begin
                    cs_n  <= 1'b1;
                    mosi  <= 1'b0;
                    gap_q <= GAP_V;
                end
            end else if (state_q == ST_GAP && gap_q != '0) begin
                gap_q <= gap_q - G_ONE;
            end
        end
    end

endmodule
